// File: rtl/vga_char_buffer.sv
// vga_char_buffer: 16x16 character-cell store for the VGA text path, with a cursor and a multi-cycle clear.
// Latency: WRITE_AT, PUTC and SET_CURSOR take effect on the accepting edge. CLEAR occupies 256 further cycles.
// Backpressure: cmd_ready is low only while a clear is running. Option VGA_CHAR_FRAME_SYNC_EN adds a back buffer copied on vsync fall.
module vga_char_buffer #(
  parameter int         DEPTH      = 256,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [7:0]            cmd_addr,
  input  logic [7:0]            cmd_data,
  input  logic                  vsync,
  output logic [DEPTH-1:0][7:0] char_data,
  output logic [7:0]            cursor,
  output logic                  busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CLR  = 1'b1
  } state_t;

  localparam logic [1:0] OP_WRITE_AT   = 2'b00;
  localparam logic [1:0] OP_PUTC       = 2'b01;
  localparam logic [1:0] OP_SET_CURSOR = 2'b10;
  localparam logic [1:0] OP_CLEAR      = 2'b11;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [8:0]            r_clr_idx;
  logic [8:0]            w_clr_idx_nxt;
  logic [7:0]            r_cursor;
  logic [7:0]            w_cursor_nxt;
  logic                  w_accept;
  logic                  w_we;
  logic [7:0]            w_waddr;
  logic [7:0]            w_wdata;
  logic [DEPTH-1:0][7:0] r_buf;

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_CLR);
  assign cursor    = r_cursor;
  assign w_accept  = cmd_valid && cmd_ready;

  // State, clear index and cursor registers; reset wins over an in-progress clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_clr_idx <= 9'd0;
      r_cursor  <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
      r_cursor  <= w_cursor_nxt;
    end
  end

  // Command decode and clear sequencing: next state, cursor and the single cell write port.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_cursor_nxt  = r_cursor;
    w_we          = 1'b0;
    w_waddr       = 8'd0;
    w_wdata       = CLEAR_CHAR;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_WRITE_AT: begin
              w_we    = 1'b1;
              w_waddr = cmd_addr;
              w_wdata = cmd_data;
            end
            OP_PUTC: begin
              case (cmd_data)
                // Next row, column 0; row 15 wraps to row 0 through 8-bit overflow.
                CH_LF: w_cursor_nxt = (r_cursor & 8'hF0) + 8'd16;
                CH_CR: w_cursor_nxt = r_cursor & 8'hF0;
                CH_BS: begin
                  if (r_cursor != 8'd0) begin
                    w_cursor_nxt = r_cursor - 8'd1;
                    w_we         = 1'b1;
                    w_waddr      = r_cursor - 8'd1;
                    w_wdata      = CLEAR_CHAR;
                  end
                end
                default: begin
                  w_we         = 1'b1;
                  w_waddr      = r_cursor;
                  w_wdata      = cmd_data;
                  w_cursor_nxt = r_cursor + 8'd1;
                end
              endcase
            end
            OP_SET_CURSOR: w_cursor_nxt = cmd_addr;
            OP_CLEAR: begin
              w_state_nxt   = S_CLR;
              w_clr_idx_nxt = 9'd0;
            end
            default: ;
          endcase
        end
      end
      S_CLR: begin
        w_we          = 1'b1;
        w_waddr       = r_clr_idx[7:0];
        w_wdata       = CLEAR_CHAR;
        w_clr_idx_nxt = r_clr_idx + 9'd1;
        // Cell 255 is written on this edge; hand control back to commands.
        if (r_clr_idx == 9'd255) begin
          w_state_nxt  = S_IDLE;
          w_cursor_nxt = 8'd0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command-side cell storage (the displayed array unless frame sync is enabled).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf <= {DEPTH{CLEAR_CHAR}};
    end else if (w_we) begin
      r_buf[w_waddr] <= w_wdata;
    end
  end

`ifdef VGA_CHAR_FRAME_SYNC_EN
  logic                  r_vsync;
  logic                  r_vsync_prev;
  logic                  w_vsync_fall;
  logic [DEPTH-1:0][7:0] r_front;

  assign w_vsync_fall = r_vsync_prev && !r_vsync;

  // Register vsync and keep its previous sample for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vsync      <= 1'b1;
      r_vsync_prev <= 1'b1;
    end else begin
      r_vsync      <= vsync;
      r_vsync_prev <= r_vsync;
    end
  end

  // Front copy: snapshot of the back buffer taken before any same-edge command write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_front <= {DEPTH{CLEAR_CHAR}};
    end else if (w_vsync_fall) begin
      r_front <= r_buf;
    end
  end

  assign char_data = r_front;
`else
  logic w_unused_vsync;

  assign w_unused_vsync = vsync;
  assign char_data      = r_buf;
`endif

endmodule

// File: tb/tb_vga_char_buffer.sv
// Bench for vga_char_buffer: table of single commands, then clear, reset-during-clear and frame-sync sequences.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
// Expected values come from the vector table and hand-derived constants via a scoreboard queue.
module tb_vga_char_buffer;

  logic                clk;
  logic                reset;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [7:0]          cmd_addr;
  logic [7:0]          cmd_data;
  logic                vsync;
  logic [255:0][7:0]   char_data;
  logic [7:0]          cursor;
  logic                busy;

  vga_char_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .vsync     (vsync),
    .char_data (char_data),
    .cursor    (cursor),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_cursor;
    logic [7:0] chk_addr;
    logic [7:0] exp_char;
  } vec_t;

  typedef struct {
    string      name;
    logic       is_cell;
    logic [7:0] addr;
    logic [7:0] exp;
  } sb_t;

  localparam logic [1:0] WA = 2'b00;
  localparam logic [1:0] PU = 2'b01;
  localparam logic [1:0] SC = 2'b10;
  localparam logic [1:0] CL = 2'b11;

  int  n_pass  = 0;
  int  n_total = 0;
  sb_t sb_q[$];
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Pop the oldest expectation and compare it with the DUT output it names.
  task automatic sb_pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      if (e.is_cell) check(e.name, {24'd0, char_data[e.addr]}, {24'd0, e.exp});
      else           check(e.name, {24'd0, cursor}, {24'd0, e.exp});
    end
  endtask

  // Count cells differing from a fill value, except one optional cell with its own value.
  function automatic int bad_cells(input logic [7:0] fill, input int skip, input logic [7:0] skip_val);
    int n = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == skip) begin
        if (char_data[i] !== skip_val) n++;
      end else if (char_data[i] !== fill) n++;
    end
    return n;
  endfunction

  // Drive one command and hold it until accepted; caller is 1 ns past a rising edge.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data);
    int waited = 0;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Make command-side writes visible on char_data (a vsync fall when frame sync is built in).
  task automatic present();
`ifdef VGA_CHAR_FRAME_SYNC_EN
    vsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vsync = 1'b1;
    repeat (2) @(posedge clk);
    #1;
`endif
  endtask

  initial begin
    int lo_cycles;
    int busy_bad;

    vecs[0]  = '{WA, 8'h05, 8'h41, 8'h00, 8'h05, 8'h41};
    vecs[1]  = '{SC, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h20};
    vecs[2]  = '{PU, 8'h00, 8'h42, 8'h00, 8'hFF, 8'h42};
    vecs[3]  = '{SC, 8'h13, 8'h00, 8'h13, 8'h13, 8'h20};
    vecs[4]  = '{PU, 8'h00, 8'h0A, 8'h20, 8'h13, 8'h20};
    vecs[5]  = '{SC, 8'hF7, 8'h00, 8'hF7, 8'hF7, 8'h20};
    vecs[6]  = '{PU, 8'h00, 8'h0A, 8'h00, 8'hF7, 8'h20};
    vecs[7]  = '{SC, 8'h27, 8'h00, 8'h27, 8'h27, 8'h20};
    vecs[8]  = '{PU, 8'h00, 8'h0D, 8'h20, 8'h20, 8'h20};
    vecs[9]  = '{PU, 8'h00, 8'h43, 8'h21, 8'h20, 8'h43};
    vecs[10] = '{PU, 8'h00, 8'h08, 8'h20, 8'h20, 8'h20};
    vecs[11] = '{WA, 8'h00, 8'h5A, 8'h20, 8'h00, 8'h5A};
    vecs[12] = '{SC, 8'h01, 8'h00, 8'h01, 8'h00, 8'h5A};
    vecs[13] = '{PU, 8'h00, 8'h08, 8'h00, 8'h00, 8'h20};
    vecs[14] = '{PU, 8'h00, 8'h08, 8'h00, 8'h00, 8'h20};
    vecs[15] = '{PU, 8'h00, 8'h0A, 8'h10, 8'h05, 8'h41};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = WA; cmd_addr = '0; cmd_data = '0; vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    check("reset_cells", bad_cells(8'h20, -1, 8'h00), 0);
    check("reset_cursor", {24'd0, cursor}, 32'h0);
    check("reset_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Single-command vectors.
    for (int i = 0; i < 16; i++) begin
      sb_q.push_back('{$sformatf("vec%0d_cursor", i), 1'b0, 8'h00, vecs[i].exp_cursor});
      sb_q.push_back('{$sformatf("vec%0d_cell", i), 1'b1, vecs[i].chk_addr, vecs[i].exp_char});
      do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data);
      sb_pop_check();
      present();
      sb_pop_check();
    end

    // Clear with a queued WRITE_AT held behind it.
    for (int i = 0; i < 256; i++) do_cmd(WA, i[7:0], 8'h55);
    present();
    check("fill_cells", bad_cells(8'h55, -1, 8'h00), 0);
    do_cmd(SC, 8'h33, 8'h00);
    cmd_op = CL; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = WA; cmd_addr = 8'h07; cmd_data = 8'h77;
    lo_cycles = 0;
    busy_bad  = 0;
    while (!cmd_ready && lo_cycles < 400) begin
      if (busy !== 1'b1) busy_bad++;
      lo_cycles++;
      @(posedge clk); #1;
    end
    check("clear_ready_low_cycles", lo_cycles, 256);
    check("clear_busy_tracks", busy_bad, 0);
    check("clear_busy_done", {31'd0, busy}, 32'd0);
    check("clear_cursor", {24'd0, cursor}, 32'h0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    present();
    check("clear_cells_queued_write", bad_cells(8'h20, 7, 8'h77), 0);

    // Reset 100 cycles into a clear.
    do_cmd(SC, 8'h44, 8'h00);
    do_cmd(WA, 8'h09, 8'h66);
    present();
    do_cmd(CL, 8'h00, 8'h00);
    repeat (99) @(posedge clk);
    #1;
    check("midclear_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_midclear_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_midclear_busy", {31'd0, busy}, 32'd0);
    check("rst_midclear_cursor", {24'd0, cursor}, 32'h0);
    check("rst_midclear_cells", bad_cells(8'h20, -1, 8'h00), 0);

`ifdef VGA_CHAR_FRAME_SYNC_EN
    // Writes stay hidden until a vsync fall; a write on the copy edge waits one more frame.
    do_cmd(WA, 8'h10, 8'h58);
    repeat (3) @(posedge clk);
    #1;
    check("fs_hidden", {24'd0, char_data[16]}, 32'h20);
    vsync = 1'b0;
    @(posedge clk); #1;
    check("fs_one_edge", {24'd0, char_data[16]}, 32'h20);
    @(posedge clk); #1;
    check("fs_two_edges", {24'd0, char_data[16]}, 32'h58);
    vsync = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vsync = 1'b0;
    @(posedge clk); #1;
    cmd_op = WA; cmd_addr = 8'h11; cmd_data = 8'h59; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    vsync = 1'b1;
    check("fs_copy_edge_hidden", {24'd0, char_data[17]}, 32'h20);
    check("fs_cursor_kept", {24'd0, cursor}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    present();
    check("fs_next_frame", {24'd0, char_data[17]}, 32'h59);
`endif

    if (sb_q.size() != 0) check("sb_leftover", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
